// File: rtl/ext_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ext_wb_arbiter
//   Shares the single register-file write port among NUM_REQ external
//   execution units (MUL/DIV, FPU, LSU, CSR, ...). A round-robin arbiter
//   picks one valid unit per cycle. Its result is formatted on capture:
//   full width, sign-extended 32-bit, or NaN-boxed 32-bit for FPR targets.
//   The formatted result goes into a single registered writeback stage.
//
// Ports
//   clk_i        in   1                      clock, rising edge
//   rst_i        in   1                      synchronous reset, active-high
//   req_i        in   NUM_REQ x ext_arb_req_t per-unit payload {rd, result, word}
//   req_valid_i  in   NUM_REQ                per-unit request valid
//   req_ready_o  out  NUM_REQ                per-unit accept (one-hot or zero)
//   wb_rd_o      out  $clog2(NUM_REGS)       writeback destination register
//   wb_data_o    out  XLEN                   formatted writeback data
//   wb_valid_o   out  1                      writeback valid
//   wb_ready_i   in   1                      regfile accepts the writeback
//
// The wb_* outputs come straight from flops. There is no combinational
// path from req_* to wb_*.
// ---------------------------------------------------------------------------

package ext_wb_arbiter_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NUM_REGS = 64;
  localparam int unsigned RD_W     = $clog2(NUM_REGS);

  // Request payload presented by each execution unit.
  typedef struct packed {
    logic [RD_W-1:0] rd;      // destination; rd >= 32 selects the FPR half
    logic [XLEN-1:0] result;  // raw result from the unit
    logic            word;    // 1: only result[31:0] is meaningful
  } ext_arb_req_t;

endpackage

module ext_wb_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  // XLEN and NUM_REGS must agree with the widths used in ext_arb_req_t.
  parameter int unsigned XLEN     = ext_wb_arbiter_pkg::XLEN,
  parameter int unsigned NUM_REGS = ext_wb_arbiter_pkg::NUM_REGS
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  ext_wb_arbiter_pkg::ext_arb_req_t [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  output logic [$clog2(NUM_REGS)-1:0]                   wb_rd_o,
  output logic [XLEN-1:0]                               wb_data_o,
  output logic                                          wb_valid_o,
  input  logic                                          wb_ready_i
);

  localparam int unsigned RD_W  = $clog2(NUM_REGS);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [RD_W-1:0]  FPR_BASE = RD_W'(32);
  localparam logic [RD_W-1:0]  RD_ZERO  = RD_W'(0);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   REQ_CNT  = (PTR_W + 1)'(NUM_REQ);

  // Formats a unit result for the regfile.
  //   word=0           : full-width result
  //   word=1, GPR dest : sign-extend the low 32 bits
  //   word=1, FPR dest : NaN-box the low 32 bits (upper bits all ones)
  function automatic logic [XLEN-1:0] format_result(
    input logic [RD_W-1:0] rd,
    input logic [XLEN-1:0] result,
    input logic            word
  );
    logic [XLEN-1:0] data;
    if (!word) begin
      data = result;
    end else if (rd >= FPR_BASE) begin
      data = {{(XLEN-32){1'b1}}, result[31:0]};
    end else begin
      data = {{(XLEN-32){result[31]}}, result[31:0]};
    end
    return data;
  endfunction

  // Round-robin pointer: the highest-priority requester this cycle.
  logic [PTR_W-1:0] ptr_r;

  // Writeback output stage.
  logic             wb_valid_r;
  logic [RD_W-1:0]  wb_rd_r;
  logic [XLEN-1:0]  wb_data_r;

  // Arbitration results.
  logic [PTR_W-1:0] grant_idx_s;
  logic             grant_found_s;
  logic [PTR_W:0]   cand_sum_s;
  logic [PTR_W-1:0] cand_idx_s;
  logic [PTR_W-1:0] ptr_next_s;

  // Handshake and capture controls.
  logic             can_accept_s;
  logic             xfer_s;
  logic             load_s;

  ext_wb_arbiter_pkg::ext_arb_req_t sel_req_s;
  logic [XLEN-1:0]  fmt_data_s;

  // The output register can take new data when it is empty or draining this cycle.
  assign can_accept_s = !wb_valid_r || wb_ready_i;

  // Round-robin search: the first valid requester at or after ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
    cand_sum_s    = '0;
    cand_idx_s    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_sum_s = {1'b0, ptr_r} + (PTR_W + 1)'(k);
      if (cand_sum_s >= REQ_CNT) begin
        cand_sum_s = cand_sum_s - REQ_CNT;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_idx_s = cand_sum_s[PTR_W-1:0];
      if (!grant_found_s && req_valid_i[cand_idx_s]) begin
        grant_idx_s   = cand_idx_s;
        grant_found_s = 1'b1;
      end else begin
        grant_idx_s   = grant_idx_s;
        grant_found_s = grant_found_s;
      end
    end
  end

  // An accept happens only outside reset and when the output stage has room.
  assign xfer_s    = grant_found_s && can_accept_s && !rst_i;
  assign sel_req_s = req_i[grant_idx_s];

  // rd==0 requests are consumed but never written back.
  assign load_s    = xfer_s && (sel_req_s.rd != RD_ZERO);

  assign fmt_data_s = format_result(sel_req_s.rd, sel_req_s.result, sel_req_s.word);

  // Pointer value after a transfer: the granted index plus one, modulo NUM_REQ.
  always_comb begin
    if (grant_idx_s == LAST_IDX) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // One-hot ready for the granted unit. All bits are zero when nothing transfers.
  always_comb begin
    req_ready_o = '0;
    if (xfer_s) begin
      req_ready_o[grant_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Pointer register: moves only on an accepted request, so a stalled grant stays put.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Writeback stage: a capture overrides a same-cycle drain. Otherwise a drain clears valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= '0;
      wb_data_r  <= '0;
    end else if (load_s) begin
      wb_valid_r <= 1'b1;
      wb_rd_r    <= sel_req_s.rd;
      wb_data_r  <= fmt_data_s;
    end else if (wb_ready_i) begin
      wb_valid_r <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_r;
    end
  end

  assign wb_valid_o = wb_valid_r;
  assign wb_rd_o    = wb_rd_r;
  assign wb_data_o  = wb_data_r;

endmodule

// File: tb/tb_ext_wb_arbiter.sv
// Self-checking bench for ext_wb_arbiter: directed vector table, a
// round-robin sequence, and randomized traffic against a reference model.
module tb_ext_wb_arbiter;
  import ext_wb_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  ext_arb_req_t [N-1:0] req;
  logic [N-1:0]     valid;
  logic [N-1:0]     ready;
  logic [5:0]       wb_rd;
  logic [63:0]      wb_data;
  logic             wb_valid;
  logic             wb_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ext_wb_arbiter #(.NUM_REQ(N), .XLEN(64), .NUM_REGS(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .wb_rd_o     (wb_rd),
    .wb_data_o   (wb_data),
    .wb_valid_o  (wb_valid),
    .wb_ready_i  (wb_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        wbr;
    logic [5:0]  rd;
    logic [63:0] res;
    logic        word;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [5:0]  exp_rd;
    logic [63:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] v, logic wbr, logic [5:0] rd, logic [63:0] res,
                              logic word, logic [3:0] er, logic ev, logic [5:0] erd, logic [63:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.wbr = wbr; t.rd = rd; t.res = res; t.word = word;
    t.exp_ready = er; t.exp_valid = ev; t.exp_rd = erd; t.exp_data = ed;
    return t;
  endfunction

  // Reference formatting written straight from the writeback rules.
  function automatic logic [63:0] ref_fmt(logic [5:0] rd, logic [63:0] res, logic word);
    if (!word) return res;
    if (rd >= 6'd32) return {32'hFFFF_FFFF, res[31:0]};
    return 64'($signed(res[31:0]));
  endfunction

  vec_t vecs[$];

  // Reference model state.
  int           m_ptr;
  logic         m_v;
  logic [5:0]   m_rd;
  logic [63:0]  m_data;
  logic         u_valid [N];
  ext_arb_req_t u_pay [N];

  initial begin
    int cnt [N];
    rst = 1'b1; valid = '0; wb_ready = 1'b1;
    for (int i = 0; i < N; i++) req[i] = '0;

    //        rst   valid    wbr   rd     res                     word  exp_ready exp_v exp_rd exp_data
    vecs.push_back(mk(1'b1, 4'b1111, 1'b1, 6'd5,  64'h1234,              1'b0, 4'b0000, 1'b0, 6'd0,  64'h0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 6'd5,  64'h1234,              1'b0, 4'b0010, 1'b1, 6'd5,  64'h1234));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 6'd5,  64'h1234,              1'b0, 4'b0000, 1'b0, 6'd0,  64'h0));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 6'd7,  64'h0000_0000_8000_0001, 1'b1, 4'b0100, 1'b1, 6'd7,  64'hFFFF_FFFF_8000_0001));
    vecs.push_back(mk(1'b0, 4'b1000, 1'b1, 6'd40, 64'h0000_0000_8000_0001, 1'b1, 4'b1000, 1'b1, 6'd40, 64'hFFFF_FFFF_8000_0001));
    vecs.push_back(mk(1'b0, 4'b0001, 1'b1, 6'd7,  64'h5,                 1'b1, 4'b0001, 1'b1, 6'd7,  64'h5));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 4'b0010, 1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 6'd9,  64'h77,                1'b0, 4'b0000, 1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 6'd9,  64'h77,                1'b0, 4'b0000, 1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 6'd9,  64'h77,                1'b0, 4'b0000, 1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 6'd9,  64'h77,                1'b0, 4'b0100, 1'b1, 6'd9,  64'h77));
    vecs.push_back(mk(1'b0, 4'b0001, 1'b1, 6'd0,  64'hDEAD,              1'b0, 4'b0001, 1'b0, 6'd0,  64'h0));
    vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 6'd11, 64'h11,                1'b0, 4'b0010, 1'b1, 6'd11, 64'h11));
    vecs.push_back(mk(1'b1, 4'b1111, 1'b0, 6'd11, 64'h11,                1'b0, 4'b0000, 1'b0, 6'd0,  64'h0));
    vecs.push_back(mk(1'b0, 4'b1111, 1'b0, 6'd12, 64'hC,                 1'b0, 4'b0001, 1'b1, 6'd12, 64'hC));
    vecs.push_back(mk(1'b0, 4'b1111, 1'b0, 6'd0,  64'hBEEF,              1'b0, 4'b0000, 1'b1, 6'd12, 64'hC));
    vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 6'd0,  64'hBEEF,              1'b0, 4'b0010, 1'b0, 6'd0,  64'h0));

    // Directed table: one row per cycle; ready is checked mid-cycle, wb_* after the edge.
    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst; valid = vecs[n].valid; wb_ready = vecs[n].wbr;
      for (int i = 0; i < N; i++) req[i] = '{rd: vecs[n].rd, result: vecs[n].res, word: vecs[n].word};
      #1;
      check($sformatf("vec%0d_ready", n), 64'(ready), 64'(vecs[n].exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_wb_valid", n), 64'(wb_valid), 64'(vecs[n].exp_valid));
      if (vecs[n].exp_valid || vecs[n].rst) begin
        check($sformatf("vec%0d_wb_rd", n), 64'(wb_rd), 64'(vecs[n].exp_rd));
        check($sformatf("vec%0d_wb_data", n), wb_data, vecs[n].exp_data);
      end
    end

    // Round-robin: all four units valid with wb_ready high -> grants 0,1,2,3,0,...
    @(negedge clk); rst = 1'b1; valid = '0; wb_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      req[i] = '{rd: 6'(20 + i), result: 64'(i), word: 1'b0};
      cnt[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rst = 1'b0; valid = 4'b1111; wb_ready = 1'b1;
      #1;
      check($sformatf("rr%0d_ready", c), 64'(ready), 64'(4'b0001 << (c % N)));
      for (int i = 0; i < N; i++) if (ready[i]) cnt[i]++;
      @(posedge clk); #1;
      check($sformatf("rr%0d_wb_rd", c), 64'(wb_rd), 64'(20 + (c % N)));
    end
    for (int i = 0; i < N; i++) check($sformatf("rr_count%0d", i), 64'(cnt[i]), 64'd2);

    // Randomized traffic against the reference model.
    @(negedge clk); rst = 1'b1; valid = '0; wb_ready = 1'b1;
    @(posedge clk);
    m_ptr = 0; m_v = 1'b0; m_rd = '0; m_data = '0;
    for (int i = 0; i < N; i++) begin u_valid[i] = 1'b0; u_pay[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      int   g;
      logic acc;
      logic r_now;
      logic [N-1:0] exp_ready;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!u_valid[i] && ($urandom_range(0, 99) < 60)) begin
          u_valid[i]       = 1'b1;
          u_pay[i].rd      = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          u_pay[i].result  = {$urandom, $urandom};
          u_pay[i].word    = 1'($urandom_range(0, 1));
        end
        valid[i] = u_valid[i];
        req[i]   = u_pay[i];
      end
      r_now    = ($urandom_range(0, 39) == 0);
      rst      = r_now;
      wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && u_valid[idx]) g = idx;
      end
      acc = !r_now && (!m_v || wb_ready) && (g >= 0);
      exp_ready = acc ? (4'b0001 << g) : 4'b0000;
      check($sformatf("rnd%0d_ready", c), 64'(ready), 64'(exp_ready));
      if (r_now) begin
        m_ptr = 0; m_v = 1'b0; m_rd = '0; m_data = '0;
      end else if (acc) begin
        m_ptr = (g + 1) % N;
        u_valid[g] = 1'b0;
        if (u_pay[g].rd != 6'd0) begin
          m_v = 1'b1; m_rd = u_pay[g].rd;
          m_data = ref_fmt(u_pay[g].rd, u_pay[g].result, u_pay[g].word);
        end else if (wb_ready) begin
          m_v = 1'b0;
        end
      end else if (wb_ready) begin
        m_v = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d_wb_valid", c), 64'(wb_valid), 64'(m_v));
      if (m_v || r_now) begin
        check($sformatf("rnd%0d_wb_rd", c), 64'(wb_rd), 64'(m_rd));
        check($sformatf("rnd%0d_wb_data", c), wb_data, m_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
